// File: rtl/waveform_monitor_if.sv
// Bundle between the AMOLED drive-waveform generator and its timing monitor.
// master: generator/stimulus side, drives the five drive controls and clr_err
//         and observes the monitor results.
// slave : the monitor, samples the drive controls and returns phase, length,
//         frame and sticky error information.
interface waveform_monitor_if #(
    parameter int unsigned CNT_W = 20
) ();

    logic             vinit;
    logic             vcomp;
    logic             vscan;
    logic             vem1;
    logic             vem2;
    logic             clr_err;

    logic [2:0]       phase_o;
    logic             frame_done;
    logic [15:0]      frame_cnt;
    logic [CNT_W-1:0] init_len;
    logic [CNT_W-1:0] comp_len;
    logic [CNT_W-1:0] scan_len;
    logic [CNT_W-1:0] emit_len;
    logic             err_overlap;
    logic             err_order;
    logic             err_short;

    modport master (
        output vinit, vcomp, vscan, vem1, vem2, clr_err,
        input  phase_o, frame_done, frame_cnt,
        input  init_len, comp_len, scan_len, emit_len,
        input  err_overlap, err_order, err_short
    );

    modport slave (
        input  vinit, vcomp, vscan, vem1, vem2, clr_err,
        output phase_o, frame_done, frame_cnt,
        output init_len, comp_len, scan_len, emit_len,
        output err_overlap, err_order, err_short
    );

endinterface

// File: rtl/waveform_monitor.sv
// Timing self-check for the AMOLED pixel-drive waveform generator.
// Registers the five drive controls, decodes the active phase, measures each
// phase length, enforces INIT->COMP->SCAN->EMIT order and minimum lengths,
// counts completed frames and raises sticky overlap/order/short errors.
// Ports:
//   clk   - system clock (generator domain)
//   reset - asynchronous active-high reset
//   bus   - waveform_monitor_if.slave: drive controls + clr_err in,
//           phase_o / frame_done / frame_cnt / *_len / err_* out (all registered)
module waveform_monitor #(
    parameter int unsigned CNT_W    = 20,
    parameter int unsigned MIN_INIT = 100,
    parameter int unsigned MIN_COMP = 200,
    parameter int unsigned MIN_SCAN = 50,
    parameter int unsigned MIN_EMIT = 1000
) (
    input logic              clk,
    input logic              reset,
    waveform_monitor_if.slave bus
);

    localparam int unsigned PH_W = 3;

    localparam logic [PH_W-1:0] PH_GAP  = 3'd0;
    localparam logic [PH_W-1:0] PH_INIT = 3'd1;
    localparam logic [PH_W-1:0] PH_COMP = 3'd2;
    localparam logic [PH_W-1:0] PH_SCAN = 3'd3;
    localparam logic [PH_W-1:0] PH_EMIT = 3'd4;
    localparam logic [PH_W-1:0] PH_ILL  = 3'd7;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // State encodings match the phase codes so a phase can be adopted directly.
    typedef enum logic [PH_W-1:0] {
        S_WAIT = 3'd0,
        S_INIT = 3'd1,
        S_COMP = 3'd2,
        S_SCAN = 3'd3,
        S_EMIT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              seq_ok_q, seq_ok_d;

    logic [4:0]        in_q;
    logic [PH_W-1:0]   phase_q;
    logic [CNT_W-1:0]  run_q;

    logic              frame_done_q;
    logic [15:0]       frame_cnt_q;
    logic [CNT_W-1:0]  init_len_q, comp_len_q, scan_len_q, emit_len_q;
    logic              err_overlap_q, err_order_q, err_short_q;

    logic [PH_W-1:0]   code_c;
    logic              legal_c;
    logic              entry_c;
    logic              ended_c;
    logic [PH_W-1:0]   succ_c;
    logic [CNT_W-1:0]  min_c;
    logic              short_c;
    logic              order_c;
    logic              frame_c;

    // Phase decode of the registered drive controls {vinit,vcomp,vscan,vem1,vem2}.
    always_comb begin
        code_c = PH_ILL;
        case (in_q)
            5'b00000: code_c = PH_GAP;
            5'b10000: code_c = PH_INIT;
            5'b01000: code_c = PH_COMP;
            5'b00100: code_c = PH_SCAN;
            5'b00011: code_c = PH_EMIT;
            default:  code_c = PH_ILL;
        endcase
    end

    // phase_q holds the previous cycle's code, so a difference marks a boundary.
    assign legal_c = (code_c != PH_GAP) && (code_c != PH_ILL);
    assign entry_c = legal_c && (code_c != phase_q);
    assign ended_c = (phase_q != PH_GAP) && (phase_q != PH_ILL) && (code_c != phase_q);

    // Minimum length for the phase that is currently ending.
    always_comb begin
        min_c = '0;
        case (phase_q)
            PH_INIT: min_c = CNT_W'(MIN_INIT);
            PH_COMP: min_c = CNT_W'(MIN_COMP);
            PH_SCAN: min_c = CNT_W'(MIN_SCAN);
            PH_EMIT: min_c = CNT_W'(MIN_EMIT);
            default: min_c = '0;
        endcase
    end

    // Short phases are only judged once the monitor has locked onto a frame.
    assign short_c = ended_c && (state_q != S_WAIT) && (run_q < min_c);

    // Legal successor of the current state.
    always_comb begin
        succ_c = PH_INIT;
        case (state_q)
            S_INIT:  succ_c = PH_COMP;
            S_COMP:  succ_c = PH_SCAN;
            S_SCAN:  succ_c = PH_EMIT;
            S_EMIT:  succ_c = PH_INIT;
            default: succ_c = PH_INIT;
        endcase
    end

    // Sequencing state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_WAIT;
            seq_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            seq_ok_q <= seq_ok_d;
        end
    end

    // Next state: react only to entry into a new legal phase. seq_ok tracks
    // whether the frame begun at the last INIT has stayed in order.
    always_comb begin
        state_d  = state_q;
        seq_ok_d = seq_ok_q;
        order_c  = 1'b0;
        frame_c  = 1'b0;
        if (entry_c) begin
            if (state_q == S_WAIT) begin
                if (code_c == PH_INIT) begin
                    state_d  = S_INIT;
                    seq_ok_d = 1'b1;
                end
            end else begin
                state_d = state_t'(code_c);
                if (code_c == succ_c) begin
                    if (code_c == PH_INIT) begin
                        frame_c  = seq_ok_q;
                        seq_ok_d = 1'b1;
                    end
                end else begin
                    order_c  = 1'b1;
                    seq_ok_d = (code_c == PH_INIT);
                end
            end
        end
    end

    // Input stage, run counter, length capture, frame counting, sticky errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q          <= '0;
            phase_q       <= PH_GAP;
            run_q         <= '0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            init_len_q    <= '0;
            comp_len_q    <= '0;
            scan_len_q    <= '0;
            emit_len_q    <= '0;
            err_overlap_q <= 1'b0;
            err_order_q   <= 1'b0;
            err_short_q   <= 1'b0;
        end else begin
            in_q    <= {bus.vinit, bus.vcomp, bus.vscan, bus.vem1, bus.vem2};
            phase_q <= code_c;

            if (legal_c) begin
                if (code_c == phase_q) begin
                    if (run_q != CNT_MAX) begin
                        run_q <= run_q + CNT_W'(1);
                    end
                end else begin
                    run_q <= CNT_W'(1);
                end
            end

            if (ended_c) begin
                case (phase_q)
                    PH_INIT: init_len_q <= run_q;
                    PH_COMP: comp_len_q <= run_q;
                    PH_SCAN: scan_len_q <= run_q;
                    PH_EMIT: emit_len_q <= run_q;
                    default: ;
                endcase
            end

            frame_done_q <= frame_c;
            if (frame_c) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end

            // A coincident set takes priority over clr_err.
            err_overlap_q <= (code_c == PH_ILL) || (err_overlap_q && !bus.clr_err);
            err_order_q   <= order_c            || (err_order_q   && !bus.clr_err);
            err_short_q   <= short_c            || (err_short_q   && !bus.clr_err);
        end
    end

    assign bus.phase_o     = phase_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.init_len    = init_len_q;
    assign bus.comp_len    = comp_len_q;
    assign bus.scan_len    = scan_len_q;
    assign bus.emit_len    = emit_len_q;
    assign bus.err_overlap = err_overlap_q;
    assign bus.err_order   = err_order_q;
    assign bus.err_short   = err_short_q;

endmodule
